ex_iter_shifter: RTL and testbench
==================================

// Module: ex_iter_shifter
// PURPOSE
//  Multi-cycle iterative shifter for the EX stage of the pipelined CPU.
//  Executes SLL/SRL/SRA (and SLLV/SRLV/SRAV once ID resolves the amount) on a 32-bit operand.
//  Shifts by up to SHIFT_PER_CYCLE bits per cycle and stalls the pipeline via stallreq while busy.
//  Fed by the EX stage; its result returns to EX for forwarding into EX/MEM.
// PARAMETERS
//  SHIFT_PER_CYCLE  4  max bits shifted per BUSY cycle; power of two, 1..32
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst       in   1   synchronous, active-high reset
//  start     in   1   request a new shift; sampled only in IDLE or DONE
//  op        in   2   00=SLL, 01=SRL, 10=SRA, 11=reserved (treated as SLL)
//  data_in   in   32  operand (rt value)
//  shamt     in   5   shift amount, 0..31 (sa field or rs[4:0])
//  cancel    in   1   flush from control; aborts an op in BUSY
//  result    out  32  shifted value, registered, holds until next completion
//  ready     out  1   one-cycle pulse: result valid this cycle
//  stallreq  out  1   pipeline stall request to ctrl
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, result=0, ready=0, internal value/remaining=0.
//  Reset mid-operation: same values; the in-flight op is discarded.
//  States: IDLE, BUSY, DONE.
//  IDLE/DONE + start=1: latch op, value<=data_in, remaining<=shamt; next state BUSY.
//  IDLE + start=0: stay IDLE. DONE + start=0: go to IDLE.
//  BUSY, every cycle: step=min(remaining,SHIFT_PER_CYCLE).
//   - SLL: value<<step; SRL: value>>step (zero fill); SRA: fill with latched bit 31.
//   - remaining<=remaining-step; if remaining-step==0 go to DONE and result<=shifted value.
//   - shamt=0 spends exactly one BUSY cycle (step 0); result=data_in.
//  BUSY cycles = max(1, ceil(shamt/SHIFT_PER_CYCLE)).
//  Latency: start sampled at edge T -> ready=1 in cycle T+1+BUSY cycles.
//  DONE: ready=1 for exactly that cycle; stallreq=0.
//  stallreq (combinational) = (state==BUSY) | (start & state!=BUSY & !cancel).
//  start while BUSY: ignored; operands must be held by EX until ready.
//  cancel in BUSY: next state IDLE, result unchanged, no ready pulse.
//  cancel in IDLE/DONE: start ignored; state goes to IDLE.
//  cancel and rst together: rst wins.
//  op=11: executes as SLL; no exception raised.
//  All arithmetic 32-bit; remaining is 6 bits wide; no wrap past 0.
// TESTING (SHIFT_PER_CYCLE=4 unless noted)
//  - SLL 0x00000404 by 16 -> 4 BUSY cycles, ready with result=0x04040000; stallreq high for 5 cycles.
//  - SRL 0x80800000 by 8 -> result=0x00808000; SRA same operands -> 0xFF808000.
//  - SRA 0xFFFF8080 by 8 -> 0xFFFFFF80; shamt=0 on 0x04040404 -> 1 BUSY cycle, result=0x04040404.
//  - SLL by 31 -> 8 BUSY cycles; ready in cycle T+9; repeat with SHIFT_PER_CYCLE=1 -> 31 BUSY cycles.
//  - cancel in 2nd BUSY cycle of SRL by 16 -> IDLE next cycle, no ready, result keeps previous value.
//  - rst in BUSY -> IDLE, result=0, ready=0; back-to-back start in DONE -> new op begins, no IDLE gap.

Source files
------------

// File: rtl/ex_iter_shifter.sv
// ----------------------------------------------------------------------------
// ex_iter_shifter
//   Multi-cycle iterative barrel-less shifter for the EX stage. Performs
//   SLL / SRL / SRA on a 32-bit operand, moving at most SHIFT_PER_CYCLE bit
//   positions per BUSY cycle, and raises stallreq so the pipeline holds the
//   operands until the result is ready.
//
// Parameters
//   SHIFT_PER_CYCLE : max bits shifted per BUSY cycle (power of two, 1..32)
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   start    in   1  request a new shift (honoured in IDLE or DONE)
//   op       in   2  00=SLL, 01=SRL, 10=SRA, 11=reserved (executes as SLL)
//   data_in  in  32  operand
//   shamt    in   5  shift amount 0..31
//   cancel   in   1  flush; aborts a BUSY op, blocks a start in IDLE/DONE
//   result   out 32  last completed result, held until the next completion
//   ready    out  1  one-cycle pulse, high during the DONE cycle
//   stallreq out  1  combinational stall request to pipeline control
// ----------------------------------------------------------------------------
module ex_iter_shifter #(
    parameter int SHIFT_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        cancel,
    output logic [31:0] result,
    output logic        ready,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] STEP_MAX = 6'(SHIFT_PER_CYCLE);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_value;
    logic [5:0]  r_remaining;
    logic        r_sign;
    logic [31:0] r_result;
    logic        r_ready;

    logic [5:0]  w_step;
    logic [5:0]  w_rem_next;
    logic [31:0] w_shifted;

    // One partial shift of n positions. SRA fills from the sign bit captured
    // at start, so the fill stays correct however many steps have elapsed.
    function automatic logic [31:0] shift_step(
        input logic [1:0]  f_op,
        input logic [31:0] f_val,
        input logic        f_sign,
        input logic [5:0]  f_n
    );
        logic [31:0] fill;
        logic [31:0] res;
        fill = f_sign ? ~(32'hFFFF_FFFF >> f_n) : 32'h0000_0000;
        case (f_op)
            2'b01:   res = f_val >> f_n;
            2'b10:   res = (f_val >> f_n) | fill;
            default: res = f_val << f_n;   // SLL and reserved encoding
        endcase
        return res;
    endfunction

    // step = min(remaining, SHIFT_PER_CYCLE); never underflows remaining
    assign w_step     = (r_remaining < STEP_MAX) ? r_remaining : STEP_MAX;
    assign w_rem_next = r_remaining - w_step;
    assign w_shifted  = shift_step(r_op, r_value, r_sign, w_step);

    assign result   = r_result;
    assign ready    = r_ready;
    assign stallreq = (r_state == ST_BUSY) |
                      (start & (r_state != ST_BUSY) & ~cancel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 2'b00;
            r_value     <= 32'h0;
            r_remaining <= 6'd0;
            r_sign      <= 1'b0;
            r_result    <= 32'h0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cancel) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_op        <= op;
                        r_value     <= data_in;
                        r_remaining <= {1'b0, shamt};
                        r_sign      <= data_in[31];
                        r_state     <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cancel) begin
                        // abort: result keeps the last completed value
                        r_state <= ST_IDLE;
                    end else begin
                        r_value     <= w_shifted;
                        r_remaining <= w_rem_next;
                        // shamt==0 reaches here with step 0 and finishes at once
                        if (w_rem_next == 6'd0) begin
                            r_state  <= ST_DONE;
                            r_result <= w_shifted;
                            r_ready  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_iter_shifter.sv
// ----------------------------------------------------------------------------
// tb_ex_iter_shifter
//   Table-driven bench for ex_iter_shifter (SHIFT_PER_CYCLE=4) with a
//   second instance at SHIFT_PER_CYCLE=1 for the slow-path latency case.
//   Expected results and ready cycles are queued when a start is driven and
//   compared when the DUT pulses ready.
// ----------------------------------------------------------------------------
module tb_ex_iter_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        cancel;
    logic [31:0] result;
    logic        ready;
    logic        stallreq;
    logic [31:0] result1;
    logic        ready1;
    logic        stallreq1;

    ex_iter_shifter #(.SHIFT_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .cancel(cancel), .result(result), .ready(ready),
        .stallreq(stallreq)
    );

    ex_iter_shifter #(.SHIFT_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .cancel(cancel), .result(result1), .ready(ready1),
        .stallreq(stallreq1)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        b2b;      // issue in the DONE cycle of the previous op
        logic [31:0] exp_res;
        int          busy;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] last_res = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got ready=1 with result 0x%08h, expected no pulse", result);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                last_res = result;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int stall_cnt;
        int t;
        exp_t e;
        if (!v.b2b) @(negedge clk);
        op      = v.op;
        data_in = v.data;
        shamt   = v.shamt;
        start   = 1'b1;
        e.res   = v.exp_res;
        e.cyc   = cyc + 1 + v.busy;
        sb.push_back(e);
        #1;
        stall_cnt = stallreq ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        #1;
        t = 0;
        while (ready !== 1'b1 && t < 100) begin
            if (stallreq) stall_cnt++;
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got no ready in 100 cycles, expected ready");
        end
        check("stall_cycles", 32'(stall_cnt), 32'(v.busy + 1));
    endtask

    vec_t vecs[12];
    int   t;
    logic seen;

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; data_in = 32'h0;
        shamt = 5'd0; cancel = 1'b0;

        vecs[0]  = '{2'b00, 32'h0000_0404, 5'd16, 1'b0, 32'h0404_0000, 4};
        vecs[1]  = '{2'b01, 32'h8080_0000, 5'd8,  1'b0, 32'h0080_8000, 2};
        vecs[2]  = '{2'b10, 32'h8080_0000, 5'd8,  1'b1, 32'hFF80_8000, 2};
        vecs[3]  = '{2'b10, 32'hFFFF_8080, 5'd8,  1'b0, 32'hFFFF_FF80, 2};
        vecs[4]  = '{2'b00, 32'h0404_0404, 5'd0,  1'b0, 32'h0404_0404, 1};
        vecs[5]  = '{2'b00, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 8};
        vecs[6]  = '{2'b11, 32'h0000_000F, 5'd4,  1'b1, 32'h0000_00F0, 1};
        vecs[7]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000, 8};
        vecs[8]  = '{2'b10, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 8};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 5'd5,  1'b0, 32'h07FF_FFFF, 2};
        vecs[10] = '{2'b00, 32'h1234_5678, 5'd3,  1'b1, 32'h91A2_B3C0, 1};
        vecs[11] = '{2'b10, 32'h8765_4321, 5'd12, 1'b0, 32'hFFF8_7654, 3};

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_ready", {31'h0, ready}, 32'h0);
        check("reset_stallreq", {31'h0, stallreq}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // cancel during the 2nd BUSY cycle of SRL by 16
        @(negedge clk);
        op = 2'b01; data_in = 32'h8080_0000; shamt = 5'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_stallreq", {31'h0, stallreq}, 32'h0);
        check("cancel_ready", {31'h0, ready}, 32'h0);
        check("cancel_result", result, last_res);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        check("cancel_no_ready", {31'h0, seen}, 32'h0);

        // cancel with start in IDLE: start is dropped
        @(negedge clk);
        op = 2'b00; data_in = 32'h1; shamt = 5'd1; start = 1'b1; cancel = 1'b1;
        #1;
        check("idle_cancel_stallreq", {31'h0, stallreq}, 32'h0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        check("idle_cancel_state", {31'h0, stallreq}, 32'h0);

        // reset in BUSY
        @(negedge clk);
        op = 2'b00; data_in = 32'hDEAD_BEEF; shamt = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy_result", result, 32'h0);
        check("rst_busy_ready", {31'h0, ready}, 32'h0);
        check("rst_busy_stallreq", {31'h0, stallreq}, 32'h0);
        last_res = 32'h0;
        repeat (10) @(negedge clk);

        // SHIFT_PER_CYCLE=1 instance: SLL by 31 takes 31 BUSY cycles
        @(negedge clk);
        op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd31; start = 1'b1;
        sb.push_back('{32'h8000_0000, cyc + 1 + 8});
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        #1;
        begin : wait1
            int k;
            k = 0;
            while (ready1 !== 1'b1 && k < 100) begin
                @(negedge clk);
                #1;
                k++;
            end
            if (k >= 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL spc1_timeout: got no ready in 100 cycles, expected ready");
            end
        end
        check("spc1_ready_cycle", 32'(cyc), 32'(t + 31));
        check("spc1_result", result1, 32'h8000_0000);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
